// File: rtl/dcp_dump.sv
// Memory dump command processor: reads DEPTH words from DM or IM and streams
// each as a hex word plus CR LF, then "FINISH" CR LF and a finish pulse.
module dcp_dump #(
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sel_mode,
    input  logic [7:0]  CMD_D,
    input  logic [31:0] din_rx,
    input  logic        ack_rx,
    output logic        req_rx_D,
    output logic        type_rx_D,
    input  logic [31:0] din_mem,
    output logic [31:0] addr_D,
    output logic        sel_dm,
    input  logic        ack_tx,
    output logic        req_tx_D,
    output logic        type_tx_D,
    output logic [31:0] dout_D,
    output logic        finish_D,
    output logic [3:0]  dbg_state
);

    // Handshakes (rx and tx): four-phase. req rises only while ack is low,
    // payload is stable from the req rise until req falls, and req falls the
    // cycle after ack is sampled high; an abort may withdraw req before ack.
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SEL     = 4'd1,
        S_RD      = 4'd2,
        S_LATCH   = 4'd3,
        S_TX_WORD = 4'd4,
        S_TX_CR   = 4'd5,
        S_TX_LF   = 4'd6,
        S_TX_FIN  = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    localparam logic [9:0] LAST_WORD = 10'(DEPTH - 1);
    localparam logic [1:0] LAT_LAST  = 2'(RD_LAT - 1);

    function automatic logic [7:0] fin_char(input logic [2:0] idx);
        case (idx)
            3'd0:    fin_char = 8'h46;
            3'd1:    fin_char = 8'h49;
            3'd2:    fin_char = 8'h4E;
            3'd3:    fin_char = 8'h49;
            3'd4:    fin_char = 8'h53;
            3'd5:    fin_char = 8'h48;
            3'd6:    fin_char = 8'h0D;
            default: fin_char = 8'h0A;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [9:0]  count_q, count_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  lat_q, lat_d;
    logic        hold_q, hold_d;
    logic        req_rx_q, req_rx_d;
    logic        req_tx_q, req_tx_d;
    logic [31:0] addr_q, addr_d;
    logic        sel_dm_q, sel_dm_d;
    logic        type_tx_q, type_tx_d;
    logic [31:0] dout_q, dout_d;
    logic        finish_q, finish_d;
    logic        sel_active, tx_state, tx_done;
    logic        unused_rx;

    assign sel_active = (sel_mode == CMD_D);
    assign tx_state   = (state_q == S_TX_WORD) || (state_q == S_TX_CR) ||
                        (state_q == S_TX_LF) || (state_q == S_TX_FIN);
    assign tx_done    = req_tx_q && ack_tx;
    assign unused_rx  = ^din_rx[31:8];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        hold_d    = hold_q;
        req_rx_d  = req_rx_q;
        req_tx_d  = req_tx_q;
        addr_d    = addr_q;
        sel_dm_d  = sel_dm_q;
        type_tx_d = type_tx_q;
        dout_d    = dout_q;
        finish_d  = 1'b0;

        // hold_q blocks a restart after a completed dump until sel_mode leaves
        if (!sel_active) hold_d = 1'b0;

        if (state_q != S_IDLE && !sel_active) begin
            state_d  = S_IDLE;
            req_rx_d = 1'b0;
            req_tx_d = 1'b0;
            count_d  = '0;
            idx_d    = '0;
            lat_d    = '0;
        end else begin
            if (tx_state) begin
                if (tx_done) req_tx_d = 1'b0;
                else if (!req_tx_q && !ack_tx) req_tx_d = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    count_d  = '0;
                    idx_d    = '0;
                    req_rx_d = 1'b0;
                    req_tx_d = 1'b0;
                    if (sel_active && !hold_q) state_d = S_SEL;
                end
                S_SEL: begin
                    if (req_rx_q && ack_rx) begin
                        req_rx_d = 1'b0;
                        sel_dm_d = (din_rx[7:0] == 8'h44);
                        addr_d   = {22'd0, count_q};
                        lat_d    = '0;
                        state_d  = S_RD;
                    end else if (!req_rx_q && !ack_rx) begin
                        req_rx_d = 1'b1;
                    end
                end
                S_RD: begin
                    if (lat_q == LAT_LAST) state_d = S_LATCH;
                    else lat_d = lat_q + 2'd1;
                end
                S_LATCH: begin
                    dout_d    = din_mem;
                    type_tx_d = 1'b1;
                    state_d   = S_TX_WORD;
                end
                S_TX_WORD: if (tx_done) begin
                    dout_d    = 32'h0D;
                    type_tx_d = 1'b0;
                    state_d   = S_TX_CR;
                end
                S_TX_CR: if (tx_done) begin
                    dout_d  = 32'h0A;
                    state_d = S_TX_LF;
                end
                S_TX_LF: if (tx_done) begin
                    count_d = count_q + 10'd1;
                    if (count_q == LAST_WORD) begin
                        idx_d   = '0;
                        dout_d  = {24'd0, fin_char(3'd0)};
                        state_d = S_TX_FIN;
                    end else begin
                        addr_d  = {22'd0, count_q + 10'd1};
                        lat_d   = '0;
                        state_d = S_RD;
                    end
                end
                S_TX_FIN: if (tx_done) begin
                    if (idx_q == 3'd7) begin
                        finish_d = 1'b1;
                        hold_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        dout_d = {24'd0, fin_char(idx_q + 3'd1)};
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            lat_q     <= '0;
            hold_q    <= 1'b0;
            req_rx_q  <= 1'b0;
            req_tx_q  <= 1'b0;
            addr_q    <= '0;
            sel_dm_q  <= 1'b0;
            type_tx_q <= 1'b0;
            dout_q    <= '0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            hold_q    <= hold_d;
            req_rx_q  <= req_rx_d;
            req_tx_q  <= req_tx_d;
            addr_q    <= addr_d;
            sel_dm_q  <= sel_dm_d;
            type_tx_q <= type_tx_d;
            dout_q    <= dout_d;
            finish_q  <= finish_d;
        end
    end

    assign req_rx_D  = req_rx_q;
    assign type_rx_D = 1'b0;
    assign req_tx_D  = req_tx_q;
    assign addr_D    = addr_q;
    assign sel_dm    = sel_dm_q;
    assign type_tx_D = type_tx_q;
    assign dout_D    = dout_q;
    assign finish_D  = finish_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dcp_dump.sv
// Bench for dcp_dump: two instances (read latency 1 and 3) share command and
// selector stimulus; each has its own memory model and handshake responders.
module tb_dcp_dump;
  localparam int DEPTH = 4;
  localparam logic [7:0] CMD = 8'hA5;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_RD = 4'd2;

  logic clk, rst;
  logic [7:0] sel_mode;
  logic [31:0] din_rx;
  logic ack_rx[2], req_rx[2], type_rx[2];
  logic [31:0] din_mem[2], addr[2], dout[2];
  logic sel_dm[2], ack_tx[2], req_tx[2], type_tx[2], finish[2];
  logic [3:0] dbg[2];

  logic [31:0] dm[DEPTH], im[DEPTH];
  logic [1:0] a0_p, a1_p0, a1_p1, a1_p2;
  int tx_dly, tx_hold;
  int fin_cnt[2], rx_rises[2], viol[2], dly_c[2], hold_c[2];
  logic req_rx_prev[2], req_tx_prev[2];
  logic [32:0] pay_prev[2];
  logic [43:0] obs_q0[$], obs_q1[$];
  logic [43:0] exp_q[$];
  int total, bad;

  dcp_dump #(.DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .sel_mode(sel_mode), .CMD_D(CMD), .din_rx(din_rx),
    .ack_rx(ack_rx[0]), .req_rx_D(req_rx[0]), .type_rx_D(type_rx[0]),
    .din_mem(din_mem[0]), .addr_D(addr[0]), .sel_dm(sel_dm[0]), .ack_tx(ack_tx[0]),
    .req_tx_D(req_tx[0]), .type_tx_D(type_tx[0]), .dout_D(dout[0]),
    .finish_D(finish[0]), .dbg_state(dbg[0]));

  dcp_dump #(.DEPTH(DEPTH), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .sel_mode(sel_mode), .CMD_D(CMD), .din_rx(din_rx),
    .ack_rx(ack_rx[1]), .req_rx_D(req_rx[1]), .type_rx_D(type_rx[1]),
    .din_mem(din_mem[1]), .addr_D(addr[1]), .sel_dm(sel_dm[1]), .ack_tx(ack_tx[1]),
    .req_tx_D(req_tx[1]), .type_tx_D(type_tx[1]), .dout_D(dout[1]),
    .finish_D(finish[1]), .dbg_state(dbg[1]));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory models: data appears exactly RD_LAT cycles after the address changes
  always @(posedge clk) begin
    a0_p  <= addr[0][1:0];
    a1_p0 <= addr[1][1:0];
    a1_p1 <= a1_p0;
    a1_p2 <= a1_p1;
  end

  always_comb begin
    din_mem[0] = sel_dm[0] ? dm[a0_p] : im[a0_p];
    din_mem[1] = sel_dm[1] ? dm[a1_p2] : im[a1_p2];
  end

  // handshake responders and protocol monitors
  initial begin
    for (int i = 0; i < 2; i++) begin
      ack_tx[i] = 0; ack_rx[i] = 0; dly_c[i] = 0; hold_c[i] = 0;
      fin_cnt[i] = 0; rx_rises[i] = 0; viol[i] = 0;
      req_rx_prev[i] = 0; req_tx_prev[i] = 0; pay_prev[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (finish[i]) fin_cnt[i]++;
      if (req_rx[i] && !req_rx_prev[i]) rx_rises[i]++;
      if (req_tx[i] && !req_tx_prev[i] && ack_tx[i]) viol[i]++;
      if (req_rx[i] && !req_rx_prev[i] && ack_rx[i]) viol[i]++;
      if (req_tx[i] && req_tx_prev[i] && {type_tx[i], dout[i]} != pay_prev[i]) viol[i]++;
      if (rst) begin
        ack_tx[i] = 0; ack_rx[i] = 0; dly_c[i] = 0; hold_c[i] = 0;
      end else begin
        if (ack_tx[i]) begin
          if (hold_c[i] <= 1) ack_tx[i] = 0;
          else hold_c[i]--;
        end else if (req_tx[i]) begin
          if (dly_c[i] >= tx_dly) begin
            ack_tx[i] = 1;
            hold_c[i] = tx_hold;
            dly_c[i] = 0;
            if (i == 0) obs_q0.push_back({sel_dm[0], addr[0][9:0], type_tx[0], dout[0]});
            else obs_q1.push_back({sel_dm[1], addr[1][9:0], type_tx[1], dout[1]});
          end else dly_c[i]++;
        end else dly_c[i] = 0;
        if (ack_rx[i]) ack_rx[i] = 0;
        else if (req_rx[i]) ack_rx[i] = 1;
      end
      req_rx_prev[i] = req_rx[i];
      req_tx_prev[i] = req_tx[i];
      pay_prev[i] = {type_tx[i], dout[i]};
    end
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // reference model: the whole character stream a dump should produce
  task automatic build_exp(input logic exp_sel);
    string f;
    logic [31:0] w;
    f = "FINISH";
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      w = exp_sel ? dm[k] : im[k];
      exp_q.push_back({exp_sel, 10'(k), 1'b1, w});
      exp_q.push_back({exp_sel, 10'(k), 1'b0, 32'h0D});
      exp_q.push_back({exp_sel, 10'(k), 1'b0, 32'h0A});
    end
    for (int k = 0; k < 6; k++) exp_q.push_back({exp_sel, 10'(DEPTH - 1), 1'b0, 24'd0, f[k]});
    exp_q.push_back({exp_sel, 10'(DEPTH - 1), 1'b0, 32'h0D});
    exp_q.push_back({exp_sel, 10'(DEPTH - 1), 1'b0, 32'h0A});
  endtask

  task automatic compare_stream(input int i, input int base, input string tag);
    logic [43:0] got;
    int n, first;
    n = (i == 0 ? obs_q0.size() : obs_q1.size()) - base;
    first = -1;
    for (int k = 0; k < exp_q.size() && first < 0; k++) begin
      if (k >= n) first = k;
      else begin
        got = (i == 0) ? obs_q0[base + k] : obs_q1[base + k];
        if (got !== exp_q[k]) first = k;
      end
    end
    if (first < 0 && n != exp_q.size()) first = exp_q.size();
    total++;
    if (first >= 0) begin
      bad++;
      if (first < n && first < exp_q.size())
        $display("FAIL %s_stream%0d: item %0d got %h expected %h", tag, i, first,
                 (i == 0) ? obs_q0[base + first] : obs_q1[base + first], exp_q[first]);
      else
        $display("FAIL %s_stream%0d: item count got %0d expected %0d", tag, i, n, exp_q.size());
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_data%0d", tag, i), {addr[i], dout[i]}, 64'd0);
      check($sformatf("%s_flags%0d", tag, i),
            {req_rx[i], type_rx[i], sel_dm[i], req_tx[i], type_tx[i], finish[i], dbg[i]}, 64'd0);
    end
  endtask

  task automatic randomize_mem();
    for (int k = 0; k < DEPTH; k++) begin
      dm[k] = $urandom();
      im[k] = $urandom();
    end
    dm[0] = dm[0] | 32'h1;
    im[0] = im[0] | 32'h1;
  endtask

  // driver: one complete dump on both instances, then scoreboard checks
  task automatic run_dump(input logic [7:0] sel, input int dly, input int hold,
                          input logic exp_sel, input string tag);
    int b0, b1, f0, f1, r0, r1, t;
    din_rx = {24'($urandom()), sel};
    tx_dly = dly;
    tx_hold = hold;
    build_exp(exp_sel);
    b0 = obs_q0.size(); b1 = obs_q1.size();
    f0 = fin_cnt[0]; f1 = fin_cnt[1];
    r0 = rx_rises[0]; r1 = rx_rises[1];
    sel_mode = CMD;
    t = 0;
    while (!(fin_cnt[0] > f0 && fin_cnt[1] > f1) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_timeout"}, 64'(t < 5000), 64'd1);
    repeat (10) @(negedge clk);
    compare_stream(0, b0, tag);
    compare_stream(1, b1, tag);
    check({tag, "_finish0"}, 64'(fin_cnt[0] - f0), 64'd1);
    check({tag, "_finish1"}, 64'(fin_cnt[1] - f1), 64'd1);
    check({tag, "_rxreq0"}, 64'(rx_rises[0] - r0), 64'd1);
    check({tag, "_rxreq1"}, 64'(rx_rises[1] - r1), 64'd1);
    sel_mode = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] sel;
    int dly;
    int hold;
    bit fixed_mem;
    logic exp_sel;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t, r0, r1;
    total = 0;
    bad = 0;
    tx_dly = 0;
    tx_hold = 1;
    sel_mode = 8'h00;
    din_rx = '0;
    rst = 1'b1;
    randomize_mem();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    vecs[0] = '{8'h44, 0, 1, 1'b1, 1'b1};
    vecs[1] = '{8'h49, 0, 1, 1'b0, 1'b0};
    vecs[2] = '{8'h44, 7, 4, 1'b0, 1'b1};
    vecs[3] = '{8'h41, 3, 2, 1'b0, 1'b0};
    vecs[4] = '{8'h64, 1, 1, 1'b0, 1'b0};
    vecs[5] = '{8'h44, $urandom_range(0, 6), $urandom_range(1, 5), 1'b0, 1'b1};

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].fixed_mem) begin
        randomize_mem();
        dm[0] = 32'h11111111; dm[1] = 32'h22222222;
        dm[2] = 32'hDEADBEEF; dm[3] = 32'h00000000;
      end else randomize_mem();
      run_dump(vecs[v].sel, vecs[v].dly, vecs[v].hold, vecs[v].exp_sel, $sformatf("vec%0d", v));
    end

    // abort during the word-2 transfer of the latency-1 instance
    randomize_mem();
    din_rx = 32'h44;
    tx_dly = 5;
    tx_hold = 2;
    r0 = fin_cnt[0]; r1 = fin_cnt[1];
    sel_mode = CMD;
    t = 0;
    while (!(req_tx[0] && type_tx[0] && addr[0] == 32'd2) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("abort_reach", 64'(t < 3000), 64'd1);
    sel_mode = 8'h00;
    @(negedge clk);
    check("abort_req0", 64'(req_tx[0]), 64'd0);
    check("abort_req1", 64'({req_tx[1], req_rx[1]}), 64'd0);
    check("abort_state0", 64'(dbg[0]), 64'(ST_IDLE));
    check("abort_state1", 64'(dbg[1]), 64'(ST_IDLE));
    repeat (5) @(negedge clk);
    check("abort_nofin0", 64'(fin_cnt[0] - r0), 64'd0);
    check("abort_nofin1", 64'(fin_cnt[1] - r1), 64'd0);
    run_dump(8'h44, 2, 3, 1'b1, "reselect");

    // asynchronous reset in the middle of a read
    randomize_mem();
    din_rx = 32'h44;
    tx_dly = 0;
    tx_hold = 1;
    sel_mode = CMD;
    t = 0;
    while (!(dbg[0] == ST_RD && addr[0] == 32'd1) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("rst_reach", 64'(t < 3000), 64'd1);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    sel_mode = 8'h00;
    @(negedge clk);
    r0 = rx_rises[0]; r1 = rx_rises[1];
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("postrst_quiet0", 64'({rx_rises[0] - r0, 31'd0, req_tx[0]}), 64'd0);
    check("postrst_quiet1", 64'({rx_rises[1] - r1, 31'd0, req_tx[1]}), 64'd0);
    run_dump(8'h49, 1, 2, 1'b0, "postrst");

    check("protocol0", 64'(viol[0]), 64'd0);
    check("protocol1", 64'(viol[1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
